// File: rtl/cp0_timer_bank.sv
// CP0-style timer bank: one prescaled free-running COUNT shared by N compare
// channels, each with one-shot or periodic re-arm and a sticky pending flag.
module cp0_timer_bank #(
  parameter int N_CHANNELS  = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int DIV_LOG2    = 1,
  localparam int AW = $clog2(2*N_CHANNELS+3),
  localparam int W  = COUNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  count_en,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [W-1:0]          wrdata,
  input  logic [AW-1:0]         raddr,
  output logic [W-1:0]          rddata,
  output logic [W-1:0]          count,
  output logic [N_CHANNELS-1:0] timer_int,
  output logic                  timer_int_any
);

  localparam int PW = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;

  logic [W-1:0]          count_q;
  logic [W-1:0]          count_inc;
  logic [PW-1:0]         presc;
  logic                  presc_full;
  logic                  tick;
  logic [N_CHANNELS-1:0] enable;
  logic [N_CHANNELS-1:0] pending;
  logic [N_CHANNELS-1:0] match;
  logic [W-1:0]          compare_arr [N_CHANNELS];
  logic [W-1:0]          period_arr  [N_CHANNELS];

  logic count_wr;
  logic enable_wr;
  logic pend_wr;

  assign count_wr  = we && (waddr == AW'(0));
  assign enable_wr = we && (waddr == AW'(1));
  assign pend_wr   = we && (waddr == AW'(2));

  generate
    if (DIV_LOG2 == 0) begin : g_no_div
      assign presc_full = 1'b1;
    end else begin : g_div
      assign presc_full = &presc;
    end
  endgenerate

  // A software load of COUNT restarts the prescaler and swallows this cycle's
  // tick, so a load can never itself produce a compare match.
  assign tick      = count_en && presc_full && !count_wr;
  assign count_inc = count_q + W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      count_q <= '0;
      enable  <= '0;
    end else begin
      if (count_wr)
        presc <= '0;
      else if (count_en && (DIV_LOG2 > 0))
        presc <= presc + PW'(1);

      if (count_wr)
        count_q <= wrdata;
      else if (tick)
        count_q <= count_inc;

      if (enable_wr)
        enable <= wrdata[N_CHANNELS-1:0];
    end
  end

  generate
    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
      logic         cmp_wr;
      logic         per_wr;
      logic [W-1:0] compare_q;
      logic [W-1:0] period_q;
      logic         pend_q;

      assign cmp_wr   = we && (waddr == AW'(3 + 2*i));
      assign per_wr   = we && (waddr == AW'(4 + 2*i));
      assign match[i] = tick && enable[i] && (count_inc == compare_q);

      // Priority on a match edge: COMPARE write beats the match, the match
      // beats a W1C, and the periodic advance uses the pre-write PERIOD.
      always_ff @(posedge clk) begin
        if (rst) begin
          compare_q <= '0;
          period_q  <= '0;
          pend_q    <= 1'b0;
        end else begin
          if (cmp_wr)
            compare_q <= wrdata;
          else if (match[i] && (period_q != '0))
            compare_q <= compare_q + period_q;

          if (per_wr)
            period_q <= wrdata;

          if (cmp_wr)
            pend_q <= 1'b0;
          else if (match[i])
            pend_q <= 1'b1;
          else if (pend_wr && wrdata[i])
            pend_q <= 1'b0;
        end
      end

      assign pending[i]     = pend_q;
      assign compare_arr[i] = compare_q;
      assign period_arr[i]  = period_q;
    end
  endgenerate

  always_comb begin
    rddata = '0;
    if (raddr == AW'(0))
      rddata = count_q;
    else if (raddr == AW'(1))
      rddata = {{(W-N_CHANNELS){1'b0}}, enable};
    else if (raddr == AW'(2))
      rddata = {{(W-N_CHANNELS){1'b0}}, pending};
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (raddr == AW'(3 + 2*i))
        rddata = compare_arr[i];
      if (raddr == AW'(4 + 2*i))
        rddata = period_arr[i];
    end
  end

  assign count         = count_q;
  assign timer_int     = pending;
  assign timer_int_any = |pending;

endmodule

// File: tb/tb_cp0_timer_bank.sv
// Directed bench for cp0_timer_bank (N=4, W=32, DIV_LOG2=1): expected values
// are queued with a tag as each step is driven and popped when checked.
module tb_cp0_timer_bank;

  logic        clk;
  logic        rst;
  logic        count_en;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wrdata;
  logic [3:0]  raddr;
  logic [31:0] rddata;
  logic [31:0] count;
  logic [3:0]  timer_int;
  logic        timer_int_any;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  cp0_timer_bank #(
    .N_CHANNELS(4),
    .COUNT_WIDTH(32),
    .DIV_LOG2(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .count_en(count_en),
    .we(we),
    .waddr(waddr),
    .wrdata(wrdata),
    .raddr(raddr),
    .rddata(rddata),
    .count(count),
    .timer_int(timer_int),
    .timer_int_any(timer_int_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_output(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] addr, input logic [31:0] data);
    we     = 1'b1;
    waddr  = addr;
    wrdata = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    we       = 1'b0;
    count_en = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_count(input string tag, input logic [31:0] v);
    expect_val(tag, v);
    check_output(count);
  endtask

  task automatic check_int(input string tag, input logic [3:0] v);
    expect_val(tag, {28'b0, v});
    check_output({28'b0, timer_int});
  endtask

  task automatic check_any(input string tag, input logic v);
    expect_val(tag, {31'b0, v});
    check_output({31'b0, timer_int_any});
  endtask

  task automatic check_reg(input string tag, input logic [3:0] addr, input logic [31:0] v);
    raddr = addr;
    #1;
    expect_val(tag, v);
    check_output(rddata);
  endtask

  initial begin
    rst      = 1'b1;
    count_en = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wrdata   = '0;
    raddr    = '0;

    // Reset state
    do_reset();
    check_count("reset_count", 32'd0);
    check_int("reset_int", 4'h0);
    check_any("reset_any", 1'b0);

    // One-shot on channel 0
    apply_stimulus(4'd3, 32'd5);
    apply_stimulus(4'd1, 32'd1);
    count_en = 1'b1;
    step(9);
    check_count("os_count4", 32'd4);
    check_int("os_int_before", 4'h0);
    step(1);
    check_count("os_count5", 32'd5);
    check_int("os_int_set", 4'h1);
    step(2);
    check_count("os_count6", 32'd6);
    check_int("os_int_held", 4'h1);
    check_reg("os_cmp_hold", 4'd3, 32'd5);
    count_en = 1'b0;
    apply_stimulus(4'd3, 32'd9);
    check_int("os_cmp_wr_clr", 4'h0);
    check_reg("os_cmp_new", 4'd3, 32'd9);

    // Periodic on channel 1
    do_reset();
    apply_stimulus(4'd5, 32'd4);
    apply_stimulus(4'd6, 32'd3);
    apply_stimulus(4'd1, 32'd2);
    count_en = 1'b1;
    step(8);
    count_en = 1'b0;
    check_count("per_count4", 32'd4);
    check_int("per_int_first", 4'h2);
    check_reg("per_cmp7", 4'd5, 32'd7);
    apply_stimulus(4'd2, 32'd2);
    check_int("per_w1c", 4'h0);
    count_en = 1'b1;
    step(6);
    count_en = 1'b0;
    check_count("per_count7", 32'd7);
    check_int("per_int_second", 4'h2);
    check_reg("per_cmp10", 4'd5, 32'd10);

    // Wrap with COMPARE=0 on channel 2
    do_reset();
    apply_stimulus(4'd0, 32'hFFFF_FFFE);
    apply_stimulus(4'd7, 32'd0);
    apply_stimulus(4'd8, 32'd2);
    apply_stimulus(4'd1, 32'd4);
    count_en = 1'b1;
    step(2);
    check_count("wrap_allones", 32'hFFFF_FFFF);
    check_int("wrap_int_before", 4'h0);
    step(2);
    count_en = 1'b0;
    check_count("wrap_zero", 32'd0);
    check_int("wrap_int_set", 4'h4);
    check_reg("wrap_cmp2", 4'd7, 32'd2);

    // W1C on the match edge: set wins
    do_reset();
    apply_stimulus(4'd3, 32'd2);
    apply_stimulus(4'd1, 32'd1);
    count_en = 1'b1;
    step(3);
    apply_stimulus(4'd2, 32'd1);
    count_en = 1'b0;
    check_count("w1c_col_count", 32'd2);
    check_int("w1c_col_int", 4'h1);

    // COMPARE write on the match edge: write wins, no periodic advance
    do_reset();
    apply_stimulus(4'd5, 32'd2);
    apply_stimulus(4'd6, 32'd5);
    apply_stimulus(4'd1, 32'd2);
    count_en = 1'b1;
    step(3);
    apply_stimulus(4'd5, 32'h100);
    count_en = 1'b0;
    check_count("cmpwr_col_count", 32'd2);
    check_int("cmpwr_col_int", 4'h0);
    check_reg("cmpwr_col_cmp", 4'd5, 32'h100);

    // PERIOD write on the match edge: advance uses the old period
    do_reset();
    apply_stimulus(4'd3, 32'd2);
    apply_stimulus(4'd4, 32'd3);
    apply_stimulus(4'd1, 32'd1);
    count_en = 1'b1;
    step(3);
    apply_stimulus(4'd4, 32'd10);
    count_en = 1'b0;
    check_int("perwr_col_int", 4'h1);
    check_reg("perwr_col_cmp", 4'd3, 32'd5);
    check_reg("perwr_col_per", 4'd4, 32'd10);

    // COUNT load equal to COMPARE must not match
    do_reset();
    apply_stimulus(4'd3, 32'd7);
    apply_stimulus(4'd1, 32'd1);
    count_en = 1'b1;
    apply_stimulus(4'd0, 32'd7);
    check_count("load_count", 32'd7);
    check_int("load_no_match", 4'h0);
    step(1);
    count_en = 1'b0;
    check_count("load_presc_cleared", 32'd7);
    check_int("load_no_match_later", 4'h0);

    // Freeze
    apply_stimulus(4'd3, 32'd8);
    step(20);
    check_count("freeze_count", 32'd7);
    check_int("freeze_int", 4'h0);

    // All four channels pending, then reset with a colliding COUNT write
    apply_stimulus(4'd5, 32'd8);
    apply_stimulus(4'd7, 32'd8);
    apply_stimulus(4'd9, 32'd8);
    apply_stimulus(4'd1, 32'hFFFF_FFFF);
    check_reg("enable_masked", 4'd1, 32'h0000_000F);
    count_en = 1'b1;
    step(1);
    check_count("all_count8", 32'd8);
    check_int("all_pending", 4'hF);
    check_any("all_any", 1'b1);
    rst    = 1'b1;
    we     = 1'b1;
    waddr  = 4'd0;
    wrdata = 32'd5;
    step(1);
    rst      = 1'b0;
    we       = 1'b0;
    count_en = 1'b0;
    check_count("rst_count", 32'd0);
    check_int("rst_int", 4'h0);
    check_any("rst_any", 1'b0);
    for (int a = 0; a < 16; a++)
      check_reg($sformatf("rst_read_%0d", a), 4'(a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_timer_bank.md
CP0_TIMER_BANK -- requirements
Module: cp0_timer_bank

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4: number of compare channels, range 1..16.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width W of COUNT, COMPARE and PERIOD; W >= 2*N_CHANNELS.
REQ-003 SHALL have parameter DIV_LOG2, default 1: COUNT advances once every 2^DIV_LOG2 enabled cycles (0 = every cycle).
REQ-004 SHALL derive localparam AW = clog2(2*N_CHANNELS+3).
REQ-005 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port count_en, input, 1: 0 freezes prescaler and COUNT.
REQ-008 SHALL have port we, input, 1: register write strobe.
REQ-009 SHALL have port waddr, input, AW: write address.
REQ-010 SHALL have port wrdata, input, W: write data.
REQ-011 SHALL have port raddr, input, AW: read address.
REQ-012 SHALL have port rddata, output, W: combinational read data.
REQ-013 SHALL have port count, output, W: current COUNT.
REQ-014 SHALL have port timer_int, output, N_CHANNELS: per-channel pending flags.
REQ-015 SHALL have port timer_int_any, output, 1: OR of timer_int.

Function
REQ-016 SHALL use this register map: 0 COUNT (RW); 1 ENABLE (RW, bits [N-1:0]); 2 PENDING (read; write-1-to-clear); 3+2i COMPARE_i (RW); 4+2i PERIOD_i (RW).
REQ-017 SHALL return 0 for unmapped reads; ENABLE and PENDING reads SHALL be zero-extended to W.
REQ-018 SHALL ignore writes to unmapped addresses, and SHALL ignore wrdata bits above N-1 for ENABLE and PENDING.
REQ-019 SHALL, when count_en=1, increment the DIV_LOG2-bit prescaler every cycle and assert tick on the cycle the prescaler equals all-ones (always for DIV_LOG2=0).
REQ-020 SHALL, on tick, set COUNT to COUNT+1 mod 2^W (wrap from all-ones to 0).
REQ-021 SHALL, on a COUNT write, load wrdata, clear the prescaler, and suppress that cycle's tick; a software load SHALL NOT produce a match.
REQ-022 SHALL assert match_i when tick=1, ENABLE[i]=1, and COUNT+1 (mod 2^W) == COMPARE_i; COMPARE_i=0 is a legal match target.
REQ-023 SHALL set PENDING[i] on the same edge at which COUNT takes the matching value; a match SHALL fire at most once per COUNT value.
REQ-024 SHALL, on match_i with PERIOD_i != 0 (periodic mode), set COMPARE_i to COMPARE_i+PERIOD_i mod 2^W on that edge; with PERIOD_i=0 (one-shot mode), COMPARE_i holds.
REQ-025 SHALL clear PENDING[i] on a COMPARE_i write.
REQ-026 SHALL clear PENDING[i] on a PENDING write with wrdata[i]=1.
REQ-027 SHALL, on simultaneous match_i and PENDING W1C of bit i, leave PENDING[i]=1 (set wins).
REQ-028 SHALL, on simultaneous match_i and COMPARE_i write, take wrdata into COMPARE_i, clear PENDING[i], and skip the periodic advance (write wins).
REQ-029 SHALL, on simultaneous match_i and PERIOD_i write, use the old PERIOD_i for the advance.
REQ-030 SHALL NOT clear PENDING[i] when ENABLE[i] is cleared; clearing ENABLE[i] only blocks new matches.
REQ-031 SHALL drive timer_int directly from the PENDING flops (registered, no combinational path from inputs), and count directly from COUNT.
REQ-032 SHALL evaluate all channels independently in the same cycle.

Reset
REQ-033 SHALL, while rst=1, reset COUNT, prescaler, ENABLE, PENDING, all COMPARE_i and all PERIOD_i to 0, so that timer_int=0, timer_int_any=0 and count=0 in the cycle after rst is sampled.
REQ-034 SHALL give rst priority over all writes and ticks, including assertion mid-count or mid-pending.

Verification (N=4, W=32, DIV_LOG2=1)
REQ-035 SHALL cover one-shot: reset, COMPARE_0=5, ENABLE=1, count_en=1 -> COUNT reaches 5 after 10 cycles, timer_int[0] rises that edge, stays high while COUNT advances to 6 and beyond; write COMPARE_0=9 -> timer_int[0]=0 next edge.
REQ-036 SHALL cover periodic: COMPARE_1=4, PERIOD_1=3, ENABLE=2 -> pending set at COUNT=4; W1C PENDING=2 clears it; COMPARE_1 reads 7; pending sets again at COUNT=7, then COMPARE_1 reads 10.
REQ-037 SHALL cover wrap: write COUNT=32'hFFFF_FFFE, COMPARE_2=0, PERIOD_2=2, ENABLE=4 -> COUNT wraps to 0, timer_int[2] sets, COMPARE_2 reads 2.
REQ-038 SHALL cover collisions: W1C on the match edge -> pending stays 1; COMPARE write on the match edge -> pending 0 and COMPARE equals written value; COUNT write equal to COMPARE -> no pending.
REQ-039 SHALL cover freeze and reset: count_en=0 for 20 cycles -> COUNT constant and no match; rst pulse with PENDING=4'hF -> all outputs 0 and all registers read 0.
